// File: rtl/banked_framebuffer_if.sv
// Two-port request/response bus of the banked framebuffer: port A (graphics core) and port B (scanout).
interface banked_framebuffer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 17
);
   logic                  validA;
   logic                  readyA;
   logic                  writeEnableA;
   logic [ADDR_WIDTH-1:0] addressA;
   logic [DATA_WIDTH-1:0] dataInA;
   logic [DATA_WIDTH-1:0] dataOutA;
   logic                  readValidA;

   logic                  validB;
   logic                  readyB;
   logic                  writeEnableB;
   logic [ADDR_WIDTH-1:0] addressB;
   logic [DATA_WIDTH-1:0] dataInB;
   logic [DATA_WIDTH-1:0] dataOutB;
   logic                  readValidB;

   modport master (
      output validA, writeEnableA, addressA, dataInA,
      input  readyA, dataOutA, readValidA,
      output validB, writeEnableB, addressB, dataInB,
      input  readyB, dataOutB, readValidB
   );

   modport slave (
      input  validA, writeEnableA, addressA, dataInA,
      output readyA, dataOutA, readValidA,
      input  validB, writeEnableB, addressB, dataInB,
      output readyB, dataOutB, readValidB
   );
endinterface

// File: rtl/banked_framebuffer.sv
// Dual-port framebuffer over BANK_COUNT single-port SRAM banks with per-bank arbitration (B priority, A starvation limit).
// Optional whole-buffer clear engine is built when FRAMEBUFFER_CLEAR_EN is defined.
module banked_framebuffer #(
   parameter int DATA_WIDTH      = 16,
   parameter int BANK_ADDR_WIDTH = 10,
   parameter int BANK_COUNT      = 94,
   parameter int ADDR_WIDTH      = 17,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic                  clk,
   input  logic                  resetN,
   banked_framebuffer_if.slave   bus,
   input  logic                  clearStart,
   input  logic [DATA_WIDTH-1:0] clearColor,
   output logic                  clearBusy
);

   localparam int BANK_IDX_WIDTH = ADDR_WIDTH - BANK_ADDR_WIDTH;
   localparam int DEPTH          = 2 ** BANK_ADDR_WIDTH;
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [BANK_IDX_WIDTH:0] BANK_END = (BANK_IDX_WIDTH + 1)'(BANK_COUNT);

   typedef enum logic {IDLE, CLEAR} state_t;

   logic [BANK_IDX_WIDTH-1:0]  bankA, bankB;
   logic [BANK_ADDR_WIDTH-1:0] rowA, rowB;
   logic                       oorA, oorB, conflict, idle, acceptA, acceptB;
   logic                       clearActive;
   logic [BANK_ADDR_WIDTH-1:0] clearRow;
   logic [DATA_WIDTH-1:0]      clearData;
   logic [3:0]                 starveCnt_q, starveCnt_d;
   logic                       readValidA_q, readValidB_q, oorA_q, oorB_q;
   logic [BANK_IDX_WIDTH-1:0]  selBankA_q, selBankB_q;
   logic [DATA_WIDTH-1:0]      holdA_q, holdB_q, readWordA, readWordB;
   logic [DATA_WIDTH-1:0]      bankRdata [BANK_COUNT];
   state_t                     state_q;

   assign bankA = bus.addressA[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
   assign bankB = bus.addressB[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
   assign rowA  = bus.addressA[BANK_ADDR_WIDTH-1:0];
   assign rowB  = bus.addressB[BANK_ADDR_WIDTH-1:0];
   assign oorA  = {1'b0, bankA} >= BANK_END;
   assign oorB  = {1'b0, bankB} >= BANK_END;

   // Out-of-range requests touch no bank, so they never collide with anything.
   assign idle     = (state_q == IDLE);
   assign conflict = bus.validA && bus.validB && !oorA && !oorB && (bankA == bankB);
   assign acceptB  = idle && bus.validB && !(conflict && (starveCnt_q == STARVE_MAX));
   assign acceptA  = idle && bus.validA && !(conflict && (starveCnt_q != STARVE_MAX));

   assign bus.readyA = acceptA;
   assign bus.readyB = acceptB;

   always_comb begin
      starveCnt_d = starveCnt_q;
      if (acceptA) begin
         starveCnt_d = '0;
      end else if (idle && conflict && (starveCnt_q != STARVE_MAX)) begin
         starveCnt_d = starveCnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         starveCnt_q <= '0;
      end else begin
         starveCnt_q <= starveCnt_d;
      end
   end

`ifdef FRAMEBUFFER_CLEAR_EN
   logic [BANK_ADDR_WIDTH-1:0] rowCnt_q;
   logic [DATA_WIDTH-1:0]      color_q;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q  <= IDLE;
         rowCnt_q <= '0;
         color_q  <= '0;
      end else if (state_q == IDLE) begin
         if (clearStart) begin
            state_q  <= CLEAR;
            rowCnt_q <= '0;
            color_q  <= clearColor;
         end
      end else begin
         if (rowCnt_q == '1) begin
            state_q <= IDLE;
         end
         rowCnt_q <= rowCnt_q + BANK_ADDR_WIDTH'(1);
      end
   end

   assign clearRow  = rowCnt_q;
   assign clearData = color_q;
`else
   logic unusedClear;

   assign state_q     = IDLE;
   assign clearRow    = '0;
   assign clearData   = '0;
   assign unusedClear = ^{clearStart, clearColor};
`endif

   assign clearActive = (state_q == CLEAR);
   assign clearBusy   = clearActive;

   // Each bank sees at most one port per cycle; the clear engine overrides both.
   for (genvar b = 0; b < BANK_COUNT; b++) begin : gBank
      localparam logic [BANK_IDX_WIDTH-1:0] IDX = BANK_IDX_WIDTH'(b);

      logic [DATA_WIDTH-1:0]      mem [DEPTH];
      logic [DATA_WIDTH-1:0]      rdata_q;
      logic                       en, we;
      logic [BANK_ADDR_WIDTH-1:0] row;
      logic [DATA_WIDTH-1:0]      wdata;

      always_comb begin
         en    = 1'b0;
         we    = 1'b0;
         row   = rowA;
         wdata = bus.dataInA;
         if (clearActive) begin
            en    = 1'b1;
            we    = 1'b1;
            row   = clearRow;
            wdata = clearData;
         end else if (acceptB && !oorB && (bankB == IDX)) begin
            en    = 1'b1;
            we    = bus.writeEnableB;
            row   = rowB;
            wdata = bus.dataInB;
         end else if (acceptA && !oorA && (bankA == IDX)) begin
            en    = 1'b1;
            we    = bus.writeEnableA;
            row   = rowA;
            wdata = bus.dataInA;
         end
      end

      always_ff @(posedge clk) begin
         if (en) begin
            if (we) begin
               mem[row] <= wdata;
            end else begin
               rdata_q <= mem[row];
            end
         end
      end

      assign bankRdata[b] = rdata_q;
   end

   // Bank read registers can be reused by the other port next cycle, so the word is captured into a hold register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         readValidA_q <= 1'b0;
         readValidB_q <= 1'b0;
         oorA_q       <= 1'b0;
         oorB_q       <= 1'b0;
         selBankA_q   <= '0;
         selBankB_q   <= '0;
         holdA_q      <= '0;
         holdB_q      <= '0;
      end else begin
         readValidA_q <= acceptA && !bus.writeEnableA;
         readValidB_q <= acceptB && !bus.writeEnableB;
         if (acceptA && !bus.writeEnableA) begin
            selBankA_q <= bankA;
            oorA_q     <= oorA;
         end
         if (acceptB && !bus.writeEnableB) begin
            selBankB_q <= bankB;
            oorB_q     <= oorB;
         end
         holdA_q <= readWordA;
         holdB_q <= readWordB;
      end
   end

   always_comb begin
      readWordA = holdA_q;
      readWordB = holdB_q;
      if (readValidA_q) begin
         readWordA = oorA_q ? '0 : bankRdata[selBankA_q];
      end
      if (readValidB_q) begin
         readWordB = oorB_q ? '0 : bankRdata[selBankB_q];
      end
   end

   assign bus.dataOutA   = readWordA;
   assign bus.dataOutB   = readWordB;
   assign bus.readValidA = readValidA_q;
   assign bus.readValidB = readValidB_q;

endmodule
